// File: rtl/axi_xbar_map_pkg.sv
// rtl/axi_xbar_map_pkg.sv - AXI request/response and address-rule types used by the crossbar map controller
package axi_xbar_map_pkg;

    typedef struct packed {
        logic [31:0] idx;
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } xbar_rule_64_t;

    typedef struct packed {
        logic [31:0] aw_addr;
        logic [5:0]  aw_atop;
        logic        aw_valid;
        logic [31:0] w_data;
        logic        w_last;
        logic        w_valid;
        logic        b_ready;
        logic [31:0] ar_addr;
        logic        ar_valid;
        logic        r_ready;
    } axi_req_t;

    typedef struct packed {
        logic        aw_ready;
        logic        w_ready;
        logic        b_valid;
        logic        ar_ready;
        logic [31:0] r_data;
        logic        r_last;
        logic        r_valid;
    } axi_resp_t;

endpackage

// File: rtl/axi_xbar_map_ctrl.sv
// rtl/axi_xbar_map_ctrl.sv - quiesce-and-commit controller for the crossbar address map
//
// Sits between upstream masters and the crossbar slave ports. A configuration
// request blocks new AW/AR issue on every port, waits until no transaction is
// outstanding, then loads the new map into the output registers in one cycle.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   slv_reqs_i / slv_resps_o      upstream AXI side, one entry per slave port
//   xbar_reqs_o / xbar_resps_i    crossbar slave-port side
//   cfg_req_i, cfg_*_i            configuration request and new map contents
//   cfg_ack_o                     one-cycle pulse while the commit happens
//   addr_map_o, en_default_mst_port_o, default_mst_port_o   registered map
//   configured_o                  set after the first commit
//   busy_o                        draining or committing
module axi_xbar_map_ctrl #(
    parameter int unsigned NoSlvPorts  = 2,
    parameter int unsigned NoMstPorts  = 2,
    parameter int unsigned NoAddrRules = 2,
    parameter int unsigned MaxTrans    = 8,
    parameter type req_t  = axi_xbar_map_pkg::axi_req_t,
    parameter type resp_t = axi_xbar_map_pkg::axi_resp_t,
    parameter type rule_t = axi_xbar_map_pkg::xbar_rule_64_t,
    localparam int unsigned IdxW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  req_t  [NoSlvPorts-1:0]           slv_reqs_i,
    output resp_t [NoSlvPorts-1:0]           slv_resps_o,
    output req_t  [NoSlvPorts-1:0]           xbar_reqs_o,
    input  resp_t [NoSlvPorts-1:0]           xbar_resps_i,
    input  logic                             cfg_req_i,
    input  rule_t [NoAddrRules-1:0]          cfg_addr_map_i,
    input  logic  [NoSlvPorts-1:0]           cfg_en_default_i,
    input  logic  [NoSlvPorts-1:0][IdxW-1:0] cfg_default_mst_i,
    output logic                             cfg_ack_o,
    output rule_t [NoAddrRules-1:0]          addr_map_o,
    output logic  [NoSlvPorts-1:0]           en_default_mst_port_o,
    output logic  [NoSlvPorts-1:0][IdxW-1:0] default_mst_port_o,
    output logic                             configured_o,
    output logic                             busy_o
);

    localparam int unsigned    CntW   = $clog2(MaxTrans + 1);
    localparam logic [CntW:0]  MaxCnt = (CntW + 1)'(MaxTrans);

    typedef enum logic [1:0] {UNCFG, RUN, DRAIN, COMMIT} state_e;

    state_e state_q, state_d;

    logic [NoSlvPorts-1:0] aw_blk_q, aw_blk_d, ar_blk_q, ar_blk_d;
    logic [NoSlvPorts-1:0] aw_held_q, aw_held_d, ar_held_q, ar_held_d;
    logic [NoSlvPorts-1:0] aw_gate, ar_gate, aw_v, ar_v;
    logic [NoSlvPorts-1:0] aw_hs, ar_hs, atop_hs, b_hs, rl_hs, wr_uf, rd_uf;
    logic [NoSlvPorts-1:0][CntW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic [NoSlvPorts-1:0][CntW:0]   rd_sum;
    logic gather, drained;

    always_comb begin
        gather      = (state_q == DRAIN) || (state_q == UNCFG);
        xbar_reqs_o = slv_reqs_i;
        slv_resps_o = xbar_resps_i;
        aw_gate = '0; ar_gate = '0; aw_v = '0; ar_v = '0;
        aw_hs = '0; ar_hs = '0; atop_hs = '0; b_hs = '0; rl_hs = '0;
        wr_uf = '0; rd_uf = '0; rd_sum = '0;
        aw_blk_d = aw_blk_q; ar_blk_d = ar_blk_q;
        aw_held_d = '0; ar_held_d = '0;
        wr_cnt_d = wr_cnt_q; rd_cnt_d = rd_cnt_q;
        drained = 1'b1;
        for (int i = 0; i < NoSlvPorts; i++) begin
            // A valid already shown to the crossbar (held) bypasses the saturation
            // gate. The room check for AR counts a held atomic AW, and the check for
            // an atomic AW counts an AR presented this cycle, so rd_cnt never overflows.
            ar_gate[i] = ar_blk_q[i] | (~ar_held_q[i] &
                (({1'b0, rd_cnt_q[i]} + (CntW + 1)'(aw_held_q[i] & slv_reqs_i[i].aw_atop[5])) >= MaxCnt));
            ar_v[i] = slv_reqs_i[i].ar_valid & ~ar_gate[i];
            aw_gate[i] = aw_blk_q[i] | (~aw_held_q[i] &
                (({1'b0, wr_cnt_q[i]} >= MaxCnt) |
                 (slv_reqs_i[i].aw_atop[5] & (({1'b0, rd_cnt_q[i]} + (CntW + 1)'(ar_v[i])) >= MaxCnt))));
            aw_v[i] = slv_reqs_i[i].aw_valid & ~aw_gate[i];

            xbar_reqs_o[i].aw_valid = aw_v[i];
            xbar_reqs_o[i].ar_valid = ar_v[i];
            // While collecting block flags, ready only follows a presented valid so an
            // idle port never advertises acceptance during a drain.
            slv_resps_o[i].aw_ready = xbar_resps_i[i].aw_ready & ~aw_gate[i] & (~gather | aw_v[i]);
            slv_resps_o[i].ar_ready = xbar_resps_i[i].ar_ready & ~ar_gate[i] & (~gather | ar_v[i]);

            aw_hs[i]   = aw_v[i] & xbar_resps_i[i].aw_ready;
            ar_hs[i]   = ar_v[i] & xbar_resps_i[i].ar_ready;
            atop_hs[i] = aw_hs[i] & slv_reqs_i[i].aw_atop[5];
            b_hs[i]    = xbar_resps_i[i].b_valid & slv_reqs_i[i].b_ready;
            rl_hs[i]   = xbar_resps_i[i].r_valid & xbar_resps_i[i].r_last & slv_reqs_i[i].r_ready;
            aw_held_d[i] = aw_v[i] & ~xbar_resps_i[i].aw_ready;
            ar_held_d[i] = ar_v[i] & ~xbar_resps_i[i].ar_ready;

            if (state_q == COMMIT) begin
                aw_blk_d[i] = 1'b0;
                ar_blk_d[i] = 1'b0;
            end else if (gather) begin
                aw_blk_d[i] = aw_blk_q[i] | ~aw_v[i] | aw_hs[i];
                ar_blk_d[i] = ar_blk_q[i] | ~ar_v[i] | ar_hs[i];
            end

            wr_uf[i]    = b_hs[i] & ~aw_hs[i] & (wr_cnt_q[i] == '0);
            wr_cnt_d[i] = wr_cnt_q[i] + CntW'(aw_hs[i]) - CntW'(b_hs[i] & ~wr_uf[i]);
            rd_sum[i]   = {1'b0, rd_cnt_q[i]} + (CntW + 1)'(ar_hs[i]) + (CntW + 1)'(atop_hs[i]);
            rd_uf[i]    = rl_hs[i] & (rd_sum[i] == '0);
            rd_cnt_d[i] = CntW'(rd_sum[i] - (CntW + 1)'(rl_hs[i] & ~rd_uf[i]));

            // Counters must be empty both now and after this cycle's handshakes;
            // this leaves one quiet cycle after the last response before commit.
            drained = drained & aw_blk_d[i] & ar_blk_d[i] &
                      (wr_cnt_q[i] == '0) & (wr_cnt_d[i] == '0) &
                      (rd_cnt_q[i] == '0) & (rd_cnt_d[i] == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNCFG:   if (cfg_req_i) state_d = COMMIT;
            RUN:     if (cfg_req_i) state_d = DRAIN;
            DRAIN:   if (drained) state_d = COMMIT;
            COMMIT:  state_d = cfg_req_i ? DRAIN : RUN;
            default: state_d = UNCFG;
        endcase
    end

    assign cfg_ack_o = (state_q == COMMIT);
    assign busy_o    = (state_q == DRAIN) || (state_q == COMMIT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q               <= UNCFG;
            aw_blk_q              <= '1;
            ar_blk_q              <= '1;
            aw_held_q             <= '0;
            ar_held_q             <= '0;
            wr_cnt_q              <= '0;
            rd_cnt_q              <= '0;
            addr_map_o            <= '0;
            en_default_mst_port_o <= '0;
            default_mst_port_o    <= '0;
            configured_o          <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_blk_q  <= aw_blk_d;
            ar_blk_q  <= ar_blk_d;
            aw_held_q <= aw_held_d;
            ar_held_q <= ar_held_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            if (state_q == COMMIT) begin
                addr_map_o            <= cfg_addr_map_i;
                en_default_mst_port_o <= cfg_en_default_i;
                default_mst_port_o    <= cfg_default_mst_i;
                configured_o          <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (wr_uf == '0);
            assert (rd_uf == '0);
        end
    end

endmodule

// File: tb/tb_axi_xbar_map_ctrl.sv
// tb/tb_axi_xbar_map_ctrl.sv - directed/randomized self-checking bench for axi_xbar_map_ctrl
module tb_axi_xbar_map_ctrl;
    import axi_xbar_map_pkg::*;

    localparam int NS = 2;
    localparam int NM = 2;
    localparam int NR = 2;
    localparam int MT = 2;
    localparam int IW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    axi_req_t  [NS-1:0] slv_reqs, xbar_reqs;
    axi_resp_t [NS-1:0] slv_resps, xbar_resps;
    logic cfg_req, ack, configured, busy;
    xbar_rule_64_t [NR-1:0] cfg_map, map_o, exp_map;
    logic [NS-1:0] cfg_en, en_o, exp_en;
    logic [NS-1:0][IW-1:0] cfg_def, def_o, exp_def;

    int n_chk = 0;
    int n_fail = 0;
    int n, k, tb_cyc, tr_cyc, rd_out;
    logic [31:0] dat;

    axi_xbar_map_ctrl #(
        .NoSlvPorts(NS), .NoMstPorts(NM), .NoAddrRules(NR), .MaxTrans(MT),
        .req_t(axi_req_t), .resp_t(axi_resp_t), .rule_t(xbar_rule_64_t)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_reqs_i(slv_reqs), .slv_resps_o(slv_resps),
        .xbar_reqs_o(xbar_reqs), .xbar_resps_i(xbar_resps),
        .cfg_req_i(cfg_req), .cfg_addr_map_i(cfg_map),
        .cfg_en_default_i(cfg_en), .cfg_default_mst_i(cfg_def),
        .cfg_ack_o(ack), .addr_map_o(map_o),
        .en_default_mst_port_o(en_o), .default_mst_port_o(def_o),
        .configured_o(configured), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic new_cfg();
        for (int r = 0; r < NR; r++) begin
            cfg_map[r].idx        = $urandom_range(0, NM - 1);
            cfg_map[r].start_addr = {$urandom, $urandom};
            cfg_map[r].end_addr   = {$urandom, $urandom};
        end
        cfg_en  = NS'($urandom);
        cfg_def = (NS * IW)'($urandom);
    endtask

    // Waits for the ack pulse, checking the old map stays in place meanwhile.
    task automatic wait_ack(output int cycles, input bit idle_chk);
        cycles = 0;
        while (cycles < 60) begin
            cyc();
            cycles++;
            chk("map_held", map_o, exp_map);
            if (idle_chk) begin
                for (int p = 0; p < NS; p++) begin
                    chk("drain_aw_ready", slv_resps[p].aw_ready, 1'b0);
                    chk("drain_ar_ready", slv_resps[p].ar_ready, 1'b0);
                end
            end
            if (ack) break;
        end
        cfg_req = 1'b0;
    endtask

    task automatic finish_cfg();
        exp_map = cfg_map;
        exp_en  = cfg_en;
        exp_def = cfg_def;
        cyc();
        chk("map_out", map_o, exp_map);
        chk("en_out", en_o, exp_en);
        chk("def_out", def_o, exp_def);
        chk("configured", configured, 1'b1);
        chk("busy_after", busy, 1'b0);
        chk("ack_pulse", ack, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_req = 1'b0;
        slv_reqs = '0; xbar_resps = '0; cfg_map = '0; cfg_en = '0; cfg_def = '0;
        exp_map = '0; exp_en = '0; exp_def = '0;
        rd_out = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 1'b0);
        chk("rst_configured", configured, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_map", map_o, '0);
        chk("rst_en", en_o, '0);
        chk("rst_def", def_o, '0);
        rst_n = 1'b1;
        cyc();

        // Unconfigured: AW/AR blocked even with crossbar ready; first commit takes 1 cycle
        for (int p = 0; p < NS; p++) begin
            xbar_resps[p].aw_ready = 1'b1;
            xbar_resps[p].ar_ready = 1'b1;
            xbar_resps[p].w_ready  = 1'b1;
            slv_reqs[p].b_ready    = 1'b1;
            slv_reqs[p].r_ready    = 1'b1;
        end
        slv_reqs[0].aw_valid = 1'b1;
        slv_reqs[0].ar_valid = 1'b1;
        #1;
        chk("uncfg_aw_valid", xbar_reqs[0].aw_valid, 1'b0);
        chk("uncfg_ar_valid", xbar_reqs[0].ar_valid, 1'b0);
        chk("uncfg_aw_ready", slv_resps[0].aw_ready, 1'b0);
        chk("uncfg_ar_ready", slv_resps[0].ar_ready, 1'b0);
        slv_reqs[0].aw_valid = 1'b0;
        slv_reqs[0].ar_valid = 1'b0;
        new_cfg();
        cfg_req = 1'b1;
        wait_ack(n, 1'b0);
        chk("lat_uncfg", n, 1);
        finish_cfg();

        // Idle reconfiguration from RUN: DRAIN then COMMIT, no ready during drain
        new_cfg();
        cfg_req = 1'b1;
        wait_ack(n, 1'b1);
        chk("lat_run_idle", n, 2);
        finish_cfg();

        // 4-beat write in flight when the request arrives
        slv_reqs[0].aw_valid = 1'b1;
        slv_reqs[0].aw_atop  = 6'b0;
        slv_reqs[0].aw_addr  = $urandom;
        dat = slv_reqs[0].aw_addr;
        #1;
        chk("run_aw_valid", xbar_reqs[0].aw_valid, 1'b1);
        chk("run_aw_addr", xbar_reqs[0].aw_addr, dat);
        chk("run_aw_ready", slv_resps[0].aw_ready, 1'b1);
        cyc();
        slv_reqs[0].aw_valid = 1'b0;
        new_cfg();
        cfg_req = 1'b1;
        for (int b = 0; b < 4; b++) begin
            slv_reqs[0].w_valid = 1'b1;
            slv_reqs[0].w_last  = (b == 3);
            slv_reqs[0].w_data  = $urandom;
            dat = slv_reqs[0].w_data;
            #1;
            chk("w_valid_pass", xbar_reqs[0].w_valid, 1'b1);
            chk("w_data_pass", xbar_reqs[0].w_data, dat);
            chk("w_ready_pass", slv_resps[0].w_ready, 1'b1);
            chk("map_held_w", map_o, exp_map);
            chk("no_ack_w", ack, 1'b0);
            cyc();
        end
        slv_reqs[0].w_valid = 1'b0;
        xbar_resps[0].b_valid = 1'b1;
        #1;
        chk("b_valid_pass", slv_resps[0].b_valid, 1'b1);
        chk("no_ack_b", ack, 1'b0);
        cyc();
        xbar_resps[0].b_valid = 1'b0;
        n = 1;
        while (!ack && n < 20) begin
            chk("map_held_b", map_o, exp_map);
            cyc();
            n++;
        end
        chk("lat_after_b", n, 2);
        cfg_req = 1'b0;
        finish_cfg();

        // AW shown to the crossbar with ready low is never withdrawn
        slv_reqs[1].aw_valid   = 1'b1;
        slv_reqs[1].aw_atop    = 6'b0;
        slv_reqs[1].aw_addr    = $urandom;
        xbar_resps[1].aw_ready = 1'b0;
        new_cfg();
        cfg_req = 1'b1;
        #1;
        chk("aw_shown", xbar_reqs[1].aw_valid, 1'b1);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("aw_not_withdrawn", xbar_reqs[1].aw_valid, 1'b1);
            chk("busy_drain", busy, 1'b1);
        end
        xbar_resps[1].aw_ready = 1'b1;
        #1;
        chk("aw_hs_ready", slv_resps[1].aw_ready, 1'b1);
        cyc();
        chk("aw_blocked_after", xbar_reqs[1].aw_valid, 1'b0);
        chk("aw_ready_blocked", slv_resps[1].aw_ready, 1'b0);
        xbar_resps[1].b_valid = 1'b1;
        cyc();
        xbar_resps[1].b_valid = 1'b0;
        slv_reqs[1].aw_valid  = 1'b0;
        wait_ack(n, 1'b0);
        chk("lat_held_aw", n, 1);
        finish_cfg();

        // Read saturation at MaxTrans on port 1
        rd_out = 0;
        for (int a = 0; a < 3; a++) begin
            slv_reqs[1].ar_valid = 1'b1;
            slv_reqs[1].ar_addr  = $urandom;
            #1;
            chk("ar_sat_valid", xbar_reqs[1].ar_valid, rd_out < MT);
            chk("ar_sat_ready", slv_resps[1].ar_ready, rd_out < MT);
            if (rd_out < MT) rd_out++;
            cyc();
        end
        xbar_resps[1].r_valid = 1'b1;
        xbar_resps[1].r_last  = 1'b1;
        xbar_resps[1].r_data  = $urandom;
        dat = xbar_resps[1].r_data;
        #1;
        chk("r_valid_pass", slv_resps[1].r_valid, 1'b1);
        chk("r_data_pass", slv_resps[1].r_data, dat);
        chk("ar_still_stalled", xbar_reqs[1].ar_valid, rd_out < MT);
        cyc();
        rd_out--;
        xbar_resps[1].r_valid = 1'b0;
        #1;
        chk("ar_released", xbar_reqs[1].ar_valid, rd_out < MT);
        cyc();
        rd_out++;
        slv_reqs[1].ar_valid = 1'b0;
        xbar_resps[1].r_valid = 1'b1;
        repeat (2) cyc();
        xbar_resps[1].r_valid = 1'b0;
        rd_out = 0;

        // Atomic AW counts as a read: one AR fits, the next stalls; drain waits for B and R
        slv_reqs[0].aw_valid = 1'b1;
        slv_reqs[0].aw_atop  = 6'b100000;
        #1;
        chk("atop_aw_valid", xbar_reqs[0].aw_valid, 1'b1);
        cyc();
        rd_out = 1;
        slv_reqs[0].aw_valid = 1'b0;
        slv_reqs[0].aw_atop  = 6'b0;
        slv_reqs[0].ar_valid = 1'b1;
        #1;
        chk("atop_ar_pass", xbar_reqs[0].ar_valid, rd_out < MT);
        cyc();
        rd_out++;
        chk("atop_ar_stall", xbar_reqs[0].ar_valid, rd_out < MT);
        slv_reqs[0].ar_valid  = 1'b0;
        xbar_resps[0].r_valid = 1'b1;
        xbar_resps[0].r_last  = 1'b1;
        cyc();
        rd_out--;
        xbar_resps[0].r_valid = 1'b0;
        new_cfg();
        cfg_req = 1'b1;
        tb_cyc = $urandom_range(2, 5);
        tr_cyc = $urandom_range(2, 5);
        k = 0;
        while (k < 30) begin
            cyc();
            k++;
            xbar_resps[0].b_valid = (k == tb_cyc);
            xbar_resps[0].r_valid = (k == tr_cyc);
            if (ack) break;
            chk("map_held_atop", map_o, exp_map);
        end
        xbar_resps[0].b_valid = 1'b0;
        xbar_resps[0].r_valid = 1'b0;
        chk("lat_atop", k, ((tb_cyc > tr_cyc) ? tb_cyc : tr_cyc) + 2);
        cfg_req = 1'b0;
        finish_cfg();

        // Reset during a drain discards the request
        slv_reqs[0].aw_valid = 1'b1;
        cyc();
        slv_reqs[0].aw_valid = 1'b0;
        new_cfg();
        cfg_req = 1'b1;
        repeat (2) cyc();
        chk("mid_drain_busy", busy, 1'b1);
        chk("mid_drain_ack", ack, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_configured", configured, 1'b0);
        chk("rst_mid_map", map_o, '0);
        cfg_req = 1'b0;
        exp_map = '0; exp_en = '0; exp_def = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
        new_cfg();
        cfg_req = 1'b1;
        wait_ack(n, 1'b0);
        chk("lat_after_reset", n, 1);
        finish_cfg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
